// File: rtl/psg_pkg.sv
// Shared definitions for the SN76489-style PSG command writer: register codes,
// byte field layout, FSM state types and the latch-byte encoder.
package psg_pkg;

    localparam logic [2:0] REG_TONE0 = 3'b000;
    localparam logic [2:0] REG_ATTN0 = 3'b001;
    localparam logic [2:0] REG_TONE1 = 3'b010;
    localparam logic [2:0] REG_ATTN1 = 3'b011;
    localparam logic [2:0] REG_TONE2 = 3'b100;
    localparam logic [2:0] REG_ATTN2 = 3'b101;
    localparam logic [2:0] REG_NOISE = 3'b110;
    localparam logic [2:0] REG_ATTN3 = 3'b111;

    localparam int LATCH_BIT = 7;
    localparam int NIBBLE_W  = 4;
    localparam int DATA_HI_W = 6;
    localparam int NOISE_W   = 3;
    localparam int CNT_W     = 16;

    typedef enum logic [1:0] {
        BUS_IDLE,
        BUS_SETUP,
        BUS_STROBE,
        BUS_GAP
    } bus_state_t;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_LATCH,
        WR_DATA
    } wr_state_t;

    // The noise register only carries a 3-bit control field; bit 3 of its latch byte is zero.
    function automatic logic [7:0] latch_byte(input logic [2:0] reg_code,
                                              input logic [NIBBLE_W-1:0] nibble);
        logic [7:0] b;
        b = '0;
        b[LATCH_BIT] = 1'b1;
        b[6:4] = reg_code;
        if (reg_code == REG_NOISE)
            b[NOISE_W-1:0] = nibble[NOISE_W-1:0];
        else
            b[NIBBLE_W-1:0] = nibble;
        return b;
    endfunction

    function automatic logic [7:0] data_byte(input logic [DATA_HI_W-1:0] freq_hi);
        return {2'b00, freq_hi};
    endfunction

endpackage

// File: rtl/psg_bus_strobe.sv
// One-byte bus timer: presents a byte for SETUP cycles, pulls we_n low for STROBE
// cycles, then holds we_n high for GAP cycles; a start on the last GAP cycle chains.
module psg_bus_strobe
    import psg_pkg::*;
#(
    parameter int SETUP_CYCLES  = 1,
    parameter int STROBE_CYCLES = 1,
    parameter int GAP_CYCLES    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] start_byte,
    output logic [7:0] psg_data,
    output logic       psg_we_n,
    output logic       strobe_end,
    output logic       done
);

    localparam logic [CNT_W-1:0] SETUP_LAST  = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] STROBE_LAST = CNT_W'(STROBE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_CYCLES - 1);

    bus_state_t       state;
    logic [CNT_W-1:0] count;

    assign strobe_end = (state == BUS_STROBE) && (count == STROBE_LAST);
    assign done       = (state == BUS_GAP) && (count == GAP_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= BUS_IDLE;
            count    <= '0;
            psg_data <= 8'h00;
            psg_we_n <= 1'b1;
        end else begin
            case (state)
                BUS_IDLE: begin
                    if (start) begin
                        state    <= BUS_SETUP;
                        psg_data <= start_byte;
                        count    <= '0;
                    end
                end
                BUS_SETUP: begin
                    if (count == SETUP_LAST) begin
                        state    <= BUS_STROBE;
                        psg_we_n <= 1'b0;
                        count    <= '0;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                BUS_STROBE: begin
                    if (count == STROBE_LAST) begin
                        state    <= BUS_GAP;
                        psg_we_n <= 1'b1;
                        count    <= '0;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                BUS_GAP: begin
                    if (count == GAP_LAST) begin
                        count <= '0;
                        if (start) begin
                            state    <= BUS_SETUP;
                            psg_data <= start_byte;
                        end else begin
                            state <= BUS_IDLE;
                        end
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                default: begin
                    state    <= BUS_IDLE;
                    psg_we_n <= 1'b1;
                    count    <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/psg_command_writer.sv
// Turns one register command per handshake into 1 or 2 PSG bus bytes, keeping a
// shadow of each tone's upper frequency bits so redundant data bytes can be skipped.
module psg_command_writer
    import psg_pkg::*;
#(
    parameter int SETUP_CYCLES   = 1,
    parameter int STROBE_CYCLES  = 1,
    parameter int GAP_CYCLES     = 1,
    parameter bit SKIP_REDUNDANT = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_channel,
    input  logic       cmd_is_attn,
    input  logic [9:0] cmd_value,
    output logic [7:0] psg_data,
    output logic       psg_we_n,
    output logic       busy
);

    wr_state_t            state;
    logic [DATA_HI_W-1:0] shadow0, shadow1, shadow2;
    logic [DATA_HI_W-1:0] freq_hi_q;
    logic [1:0]           chan_q;
    logic                 pending_q;

    logic                 capture;
    logic                 is_tone;
    logic [DATA_HI_W-1:0] shadow_sel;
    logic                 needs_data;
    logic                 bus_start;
    logic [7:0]           bus_byte;
    logic                 bus_done;
    logic                 strobe_end;

    assign capture = cmd_valid && cmd_ready;
    assign is_tone = !cmd_is_attn && (cmd_channel != 2'd3);
    assign busy    = ~cmd_ready;

    // The latch byte is encoded straight from the inputs so the bus enters SETUP on the capture edge.
    always_comb begin
        shadow_sel = '0;
        case (cmd_channel)
            2'd0:    shadow_sel = shadow0;
            2'd1:    shadow_sel = shadow1;
            2'd2:    shadow_sel = shadow2;
            default: shadow_sel = '0;
        endcase
        needs_data = is_tone && !(SKIP_REDUNDANT && (cmd_value[9:4] == shadow_sel));
        bus_start  = capture || ((state == WR_LATCH) && bus_done && pending_q);
        if (state == WR_IDLE)
            bus_byte = latch_byte({cmd_channel, cmd_is_attn}, cmd_value[3:0]);
        else
            bus_byte = data_byte(freq_hi_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= WR_IDLE;
            cmd_ready <= 1'b1;
            pending_q <= 1'b0;
            freq_hi_q <= '0;
            chan_q    <= '0;
            shadow0   <= '0;
            shadow1   <= '0;
            shadow2   <= '0;
        end else begin
            case (state)
                WR_IDLE: begin
                    if (capture) begin
                        state     <= WR_LATCH;
                        cmd_ready <= 1'b0;
                        pending_q <= needs_data;
                        freq_hi_q <= cmd_value[9:4];
                        chan_q    <= cmd_channel;
                    end
                end
                WR_LATCH: begin
                    if (bus_done) begin
                        if (pending_q) begin
                            state <= WR_DATA;
                        end else begin
                            state     <= WR_IDLE;
                            cmd_ready <= 1'b1;
                        end
                    end
                end
                WR_DATA: begin
                    if (strobe_end) begin
                        case (chan_q)
                            2'd0:    shadow0 <= freq_hi_q;
                            2'd1:    shadow1 <= freq_hi_q;
                            2'd2:    shadow2 <= freq_hi_q;
                            default: ;
                        endcase
                    end
                    if (bus_done) begin
                        state     <= WR_IDLE;
                        cmd_ready <= 1'b1;
                        pending_q <= 1'b0;
                    end
                end
                default: begin
                    state     <= WR_IDLE;
                    cmd_ready <= 1'b1;
                end
            endcase
        end
    end

    psg_bus_strobe #(
        .SETUP_CYCLES (SETUP_CYCLES),
        .STROBE_CYCLES(STROBE_CYCLES),
        .GAP_CYCLES   (GAP_CYCLES)
    ) u_bus (
        .clk       (clk),
        .reset     (reset),
        .start     (bus_start),
        .start_byte(bus_byte),
        .psg_data  (psg_data),
        .psg_we_n  (psg_we_n),
        .strobe_end(strobe_end),
        .done      (bus_done)
    );

endmodule
